// File: rtl/ibex_pkg.sv
// ibex_pkg: shared types for the vector store engine.
//   vsew_e      - element width encodings (8/16/32 bit)
//   vlmul_e     - register group multiplier encodings (1/2/4)
//   vst_state_e - store engine FSM states
//   vst_legal() - legality check applied to a start request
package ibex_pkg;

    localparam int unsigned VLEN = 32;

    typedef enum logic [2:0] {
        VSEW_8  = 3'b000,
        VSEW_16 = 3'b001,
        VSEW_32 = 3'b010
    } vsew_e;

    typedef enum logic [2:0] {
        VLMUL_1 = 3'b000,
        VLMUL_2 = 3'b001,
        VLMUL_4 = 3'b010
    } vlmul_e;

    typedef enum logic [2:0] {
        VST_IDLE,
        VST_FETCH,
        VST_REQ,
        VST_WAIT,
        VST_DONE
    } vst_state_e;

    // Encodings in range, vs3 aligned to the group size, vl fits the group,
    // base word aligned.
    function automatic logic vst_legal(input logic [2:0] vsew,
                                       input logic [2:0] vlmul,
                                       input logic [4:0] vs3,
                                       input logic [4:0] vl,
                                       input logic [1:0] base_lo);
        logic [4:0] lmul;
        logic [5:0] max_vl;
        if (vsew > VSEW_32 || vlmul > VLMUL_4) return 1'b0;
        lmul   = 5'd1 << vlmul;
        max_vl = (6'd4 >> vsew) << vlmul;
        if ((vs3 & (lmul - 5'd1)) != 5'd0) return 1'b0;
        if ({1'b0, vl} > max_vl) return 1'b0;
        if (base_lo != 2'b00) return 1'b0;
        return 1'b1;
    endfunction

endpackage

// File: rtl/ibex_vector_store_be.sv
// ibex_vector_store_be: byte enables and last-word flag for word k of a
// store of bytes_i bytes.
//   bytes_i  total byte count of the store (vl * SEW/8)
//   k_i      word index within the store
//   be_o     byte enables for word k
//   last_o   word k is the final word of the store
module ibex_vector_store_be
    import ibex_pkg::*;
(
    input  logic [6:0] bytes_i,
    input  logic [1:0] k_i,
    output logic [3:0] be_o,
    output logic       last_o
);

    logic [6:0] rem;

    assign rem    = bytes_i - {3'b000, k_i, 2'b00};
    // A partial word only ever holds 1..3 bytes, so the low two bits suffice.
    assign be_o   = (rem >= 7'd4) ? 4'b1111 : ((4'b0001 << rem[1:0]) - 4'b0001);
    assign last_o = (rem <= 7'd4);

endmodule

// File: rtl/ibex_vector_store_unit.sv
// ibex_vector_store_unit: unit-stride vector store engine. Reads a register
// group one VLEN register per cycle of FETCH and writes each register as one
// 32-bit word on the data-memory port, one request outstanding at a time.
//   clk_i, rst_ni                       clock, async active-low reset
//   start_i, base_addr_i, vs3_i,
//   vsew_i, vlmul_i, vl_i               operation request (taken in IDLE)
//   vreg_raddr_o / vreg_rdata_i         register-file read port
//   data_req_o, data_we_o, data_addr_o,
//   data_be_o, data_wdata_o             memory request (all registered)
//   data_gnt_i, data_rvalid_i,
//   data_err_i                          memory handshake/response
//   busy_o, done_o, err_o               status
module ibex_vector_store_unit
    import ibex_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [31:0]     base_addr_i,
    input  logic [4:0]      vs3_i,
    input  logic [2:0]      vsew_i,
    input  logic [2:0]      vlmul_i,
    input  logic [4:0]      vl_i,
    output logic [4:0]      vreg_raddr_o,
    input  logic [VLEN-1:0] vreg_rdata_i,
    output logic            data_req_o,
    output logic            data_we_o,
    input  logic            data_gnt_i,
    input  logic            data_rvalid_i,
    input  logic            data_err_i,
    output logic [31:0]     data_addr_o,
    output logic [3:0]      data_be_o,
    output logic [31:0]     data_wdata_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o
);

    vst_state_e  state_q, state_d;
    logic [31:0] base_q;
    logic [4:0]  vs3_q;
    logic [6:0]  bytes_q;
    logic [1:0]  k_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic        err_q;

    logic        legal;
    logic [3:0]  be_w;
    logic        last_w;

    assign legal = vst_legal(vsew_i, vlmul_i, vs3_i, vl_i, base_addr_i[1:0]);

    ibex_vector_store_be u_be (
        .bytes_i (bytes_q),
        .k_i     (k_q),
        .be_o    (be_w),
        .last_o  (last_w)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            VST_IDLE: begin
                if (start_i) begin
                    // Illegal and empty requests finish without memory traffic.
                    state_d = (!legal || vl_i == 5'd0) ? VST_DONE : VST_FETCH;
                end
            end
            VST_FETCH: state_d = VST_REQ;
            VST_REQ:   if (data_gnt_i) state_d = VST_WAIT;
            VST_WAIT: begin
                if (data_rvalid_i) begin
                    state_d = (data_err_i || last_w) ? VST_DONE : VST_FETCH;
                end
            end
            VST_DONE:  state_d = VST_IDLE;
            default:   state_d = VST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= VST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            base_q  <= '0;
            vs3_q   <= '0;
            bytes_q <= '0;
            k_q     <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                VST_IDLE: begin
                    if (start_i) begin
                        base_q  <= base_addr_i;
                        vs3_q   <= vs3_i;
                        // Shift by SEW encoding: 8b->x1, 16b->x2, 32b->x4.
                        bytes_q <= {2'b00, vl_i} << vsew_i[1:0];
                        k_q     <= '0;
                        err_q   <= ~legal;
                    end
                end
                VST_FETCH: begin
                    wdata_q <= vreg_rdata_i;
                    addr_q  <= base_q + {28'd0, k_q, 2'b00};
                    be_q    <= be_w;
                end
                VST_WAIT: begin
                    if (data_rvalid_i) begin
                        if (data_err_i) err_q <= 1'b1;
                        else if (!last_w) k_q <= k_q + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // vs3_q and k_q are zero out of reset, so the read address resets to 0.
    assign vreg_raddr_o = vs3_q + {3'b000, k_q};
    assign data_req_o   = (state_q == VST_REQ);
    assign data_we_o    = (state_q == VST_REQ);
    assign data_addr_o  = addr_q;
    assign data_be_o    = be_q;
    assign data_wdata_o = wdata_q;
    assign busy_o       = (state_q != VST_IDLE);
    assign done_o       = (state_q == VST_DONE);
    assign err_o        = err_q;

endmodule

// File: doc/ibex_vector_store_unit.md
# ibex_vector_store_unit

Unit-stride vector store engine: the memory-bound counterpart of the vector register file's load write path. On a start pulse it reads a register group, one VLEN=32 register per memory word, through a register-file read port. It issues one 32-bit store per word on the Ibex data-memory interface, with byte enables derived from vsew/vl. It sits between the vector decode/CSR logic and the LSU data port, which it owns while busy.

## Interface
- VLEN, 32: vector register width; one register equals one memory word (only 32 is supported).
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- start_i  in  1  start pulse; ignored unless idle
- base_addr_i  in  32  store base byte address; must be word aligned
- vs3_i  in  5  first source vector register
- vsew_i  in  3  000=8b, 001=16b, 010=32b; others illegal
- vlmul_i  in  3  000=1, 001=2, 010=4 registers; others illegal
- vl_i  in  5  element count, 0..16
- vreg_raddr_o  out  5  register-file read address
- vreg_rdata_i  in  VLEN  register-file read data, combinational from the address
- data_req_o, data_we_o  out  1  memory request; write flag, 1 while the request is up
- data_gnt_i, data_rvalid_i, data_err_i  in  1  grant, response valid, response error
- data_addr_o  out  32  word address
- data_be_o  out  4  byte enables
- data_wdata_o  out  32  store data
- busy_o  out  1  high from the cycle after start until done
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  sticky error status of the last operation; cleared on the next accepted start

## Operation
- Start is accepted in IDLE. The unit latches base, vs3, vsew, vlmul and vl, and clears err_o.
- Legality check: vsew and vlmul in range, vs3 aligned to LMUL (vs3 mod LMUL = 0), vl ≤ (32/SEW)·LMUL, base[1:0]=0.
  - Illegal: go to DONE with err_o=1 and no memory traffic.
- Byte count: bytes = vl·(SEW/8).
  - words = ceil(bytes/4).
  - vl=0: go to DONE, err_o=0, no traffic.
- FSM states: IDLE, FETCH, REQ, WAIT, DONE.
  - FETCH: vreg_raddr_o = vs3+k. Register vreg_rdata_i into the wdata register. Compute addr = base+4k. Compute be = 1111 if bytes−4k ≥ 4, else (1<<(bytes−4k))−1. Go to REQ.
  - REQ: data_req_o=1. Hold addr, be and wdata stable. On data_gnt_i go to WAIT.
  - WAIT: on data_rvalid_i:
    - data_err_i=1: go to DONE with err_o=1 and abandon the remaining words.
    - last word: go to DONE.
    - otherwise: k++, go to FETCH.
  - DONE: done_o=1 for one cycle, then IDLE.
- Only one request is ever outstanding.
- data_rvalid_i outside WAIT is ignored.
- start_i while busy is ignored.

## Timing
- Reset values: data_req_o, data_we_o, busy_o, done_o, err_o = 0; data_addr_o, data_be_o, data_wdata_o, vreg_raddr_o = 0; state = IDLE.
- Per word: FETCH 1 cycle + REQ ≥1 cycle + WAIT ≥1 cycle. The minimum is 3 cycles per word with a same-cycle grant and rvalid one cycle after the grant.
- Accepted start at cycle 0 gives FETCH at cycle 1. For N words at minimum latency, done_o is high at cycle 3N+1.
- Illegal or vl=0: done_o at cycle 1.
- All memory outputs are registered; none depend combinationally on gnt or rvalid.
- Reset mid-operation: the request drops asynchronously and the transfer is abandoned without completion. The next start proceeds normally.

## Structure
- ibex_pkg gets:
  - vsew_e and vlmul_e enums;
  - vst_state_e (IDLE/FETCH/REQ/WAIT/DONE).
- Sub-module ibex_vector_store_be: combinational byte-enable and last-word logic from bytes and k.

## Test plan
- vsew=010, vlmul=001, vs3=2, vl=2, base=0x1000, v2=0xDEADBEEF, v3=0x01234567, immediate gnt, rvalid the next cycle:
  - Expect stores 0x1000/0xDEADBEEF/1111 then 0x1004/0x01234567/1111.
  - done_o at cycle 7, err_o=0.
- vsew=000, vlmul=001, vs3=4, vl=6, base=0x2000:
  - Expect 0x2000 be=1111 with v4, then 0x2004 be=0011 with v5, then done.
- gnt withheld 3 cycles on word 0:
  - Expect data_req_o held high with addr, be and wdata unchanged until the gnt cycle.
- Illegal cases: vs3=3 with vlmul=001; vsew=011; vl=9 with vsew=000 and vlmul=000:
  - Each gives done_o at cycle 1, err_o=1, and no data_req_o.
  - vl=0 gives done_o with err_o=0.
- data_err_i=1 with the first rvalid of a 4-word store:
  - Expect done_o next cycle, err_o=1, and exactly one request issued.
- rst_ni low during WAIT:
  - Expect all outputs 0 immediately.
  - A new start then completes one word cleanly.
